// File: rtl/unigate_pkg.sv
// Shared field layout, reference-mode constants and result payload for unigate_core.
package unigate_pkg;

  localparam int unsigned IO_W     = 38;
  localparam int unsigned CELL_LSB = 5;
  localparam int unsigned CELL_W   = 27;
  localparam int unsigned RES_LSB  = 32;
  localparam int unsigned RES_W    = 6;

  // Cell fields of c, MSB of each field is letter g
  localparam int unsigned U21_LSB = 0;
  localparam int unsigned U21_W   = 4;
  localparam int unsigned U31_LSB = 4;
  localparam int unsigned U31_W   = 6;
  localparam int unsigned U41_LSB = 10;
  localparam int unsigned U41_W   = 10;
  localparam int unsigned U22_LSB = 20;
  localparam int unsigned U22_W   = 6;
  localparam int unsigned MUX_BIT = 26;

  // Reference-mode decode
  localparam int unsigned REF_MODE_BIT = 26;
  localparam logic [3:0]  REF_MAGIC    = 4'b0011;
  localparam int unsigned SEL_LSB      = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned FUNC_LSB     = 6;
  localparam int unsigned FUNC_W       = 16;
  localparam int unsigned PIN_LSB      = 22;
  localparam int unsigned PIN_W        = 4;

  typedef enum logic [1:0] {
    SEL_U21 = 2'd0,
    SEL_U31 = 2'd1,
    SEL_U41 = 2'd2,
    SEL_U22 = 2'd3
  } ref_sel_e;

  typedef struct packed {
    logic mux;
    logic u22_1;
    logic u22_0;
    logic u41;
    logic u31;
    logic u21;
  } result_t;

  function automatic logic is_ref_mode(input logic [CELL_W-1:0] c);
    return c[REF_MODE_BIT] && (c[U21_LSB +: U21_W] == REF_MAGIC);
  endfunction

endpackage

// File: rtl/unigate_if.sv
// Pad/bus bundle of the Caravel user-project wrapper seen by unigate_core.
interface unigate_if;
  logic         wbs_stb_i;
  logic         wbs_cyc_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i;
  logic [31:0]  wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_in;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;
  logic [2:0]   irq;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output la_data_in, la_oenb, io_in,
    input  wbs_ack_o, wbs_dat_o, la_data_out, io_out, io_oeb, irq
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  la_data_in, la_oenb, io_in,
    output wbs_ack_o, wbs_dat_o, la_data_out, io_out, io_oeb, irq
  );
endinterface

// File: rtl/unigate_u2.sv
// Primitive U2 cell: g selects between h^j and i^j.
module unigate_u2 (
  input  logic g,
  input  logic h,
  input  logic i,
  input  logic j,
  output logic y_c
);
  assign y_c = g ? (h ^ j) : (i ^ j);
endmodule

// File: rtl/unigate_core.sv
// Configurable gate-cell bank with truth-table reference mode on the GPIO pads.
// Define UNIGATE_OUTREG_EN to register io_out[37:32] on wb_clk_i.
module unigate_core
  import unigate_pkg::*;
(
  input logic      wb_clk_i,
  input logic      wb_rst_n,
  unigate_if.slave bus
);

  logic [CELL_W-1:0] c;
  logic [U21_W-1:0]  f21;
  logic [U31_W-1:0]  f31;
  logic [U41_W-1:0]  f41;
  logic [U22_W-1:0]  f22;

  assign c   = bus.io_in[CELL_LSB +: CELL_W];
  assign f21 = c[U21_LSB +: U21_W];
  assign f31 = c[U31_LSB +: U31_W];
  assign f41 = c[U41_LSB +: U41_W];
  assign f22 = c[U22_LSB +: U22_W];

  result_t res_norm;

  // u21 = U2(g,h,i,j)
  unigate_u2 u_u21 (.g(f21[3]), .h(f21[2]), .i(f21[1]), .j(f21[0]), .y_c(res_norm.u21));

  // U3(g..l) = g ? U2(h,i,j,l) : k^l, built as U2(g, inner, k^l, 0)
  logic u31_in;
  unigate_u2 u_u31_in  (.g(f31[4]), .h(f31[3]), .i(f31[2]), .j(f31[0]), .y_c(u31_in));
  unigate_u2 u_u31_sel (.g(f31[5]), .h(u31_in), .i(f31[1] ^ f31[0]), .j(1'b0),
                        .y_c(res_norm.u31));

  // u41 = g ? U3(h,i,j,k,l,p) : U2(m,n,o,p)
  logic u41_u3_in;
  logic u41_u3;
  logic u41_lo;
  unigate_u2 u_u41_u3_in  (.g(f41[7]), .h(f41[6]), .i(f41[5]), .j(f41[0]), .y_c(u41_u3_in));
  unigate_u2 u_u41_u3_sel (.g(f41[8]), .h(u41_u3_in), .i(f41[4] ^ f41[0]), .j(1'b0),
                           .y_c(u41_u3));
  unigate_u2 u_u41_lo     (.g(f41[3]), .h(f41[2]), .i(f41[1]), .j(f41[0]), .y_c(u41_lo));
  unigate_u2 u_u41_sel    (.g(f41[9]), .h(u41_u3), .i(u41_lo), .j(1'b0), .y_c(res_norm.u41));

  // u22 outputs share i and l; the select mux is a U2 with j tied low
  unigate_u2 u_u22_hi (.g(f22[5]), .h(f22[4]), .i(f22[3]), .j(f22[0]), .y_c(res_norm.u22_1));
  unigate_u2 u_u22_lo (.g(f22[2]), .h(f22[1]), .i(f22[3]), .j(f22[0]), .y_c(res_norm.u22_0));
  unigate_u2 u_mux    (.g(c[MUX_BIT]), .h(res_norm.u22_1), .i(res_norm.u22_0), .j(1'b0),
                       .y_c(res_norm.mux));

  // Reference-mode truth-table lookup
  ref_sel_e          ref_sel;
  logic [FUNC_W-1:0] ref_func;
  logic [PIN_W-1:0]  ref_pin;
  logic [RES_W-1:0]  res_ref;
  logic              ref_lo;
  logic              ref_hi;

  assign ref_sel  = ref_sel_e'(c[SEL_LSB +: SEL_W]);
  assign ref_func = c[FUNC_LSB +: FUNC_W];
  assign ref_pin  = c[PIN_LSB +: PIN_W];
  assign ref_lo   = ref_func[{2'b00, ref_pin[1:0]}];
  assign ref_hi   = ref_func[{2'b01, ref_pin[1:0]}];

  always_comb begin
    res_ref = '0;
    unique case (ref_sel)
      SEL_U21: res_ref[0] = ref_lo;
      SEL_U31: res_ref[1] = ref_func[{1'b0, ref_pin[2:0]}];
      SEL_U41: res_ref[2] = ref_func[ref_pin];
      SEL_U22: begin
        res_ref[3] = ref_lo;
        res_ref[4] = ref_hi;
        res_ref[5] = ref_pin[2] ? ref_hi : ref_lo;
      end
      default: res_ref = '0;
    endcase
  end

  logic [RES_W-1:0] r_c;
  logic [RES_W-1:0] r_pad;

  assign r_c = is_ref_mode(c) ? res_ref : RES_W'(res_norm);

`ifdef UNIGATE_OUTREG_EN
  logic [RES_W-1:0] r_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) r_q <= '0;
    else           r_q <= r_c;
  end

  assign r_pad = r_q;
`else
  assign r_pad = r_c;
`endif

  assign bus.io_out      = {r_pad, 32'h0000_0000};
  assign bus.io_oeb      = {{RES_W{1'b0}}, 32'hFFFF_FFFF};
  assign bus.wbs_ack_o   = 1'b0;
  assign bus.wbs_dat_o   = '0;
  assign bus.la_data_out = '0;
  assign bus.irq         = '0;

  // Ignored inputs folded into one sink
  logic unused_ok;
  assign unused_ok = ^{bus.wbs_stb_i, bus.wbs_cyc_i, bus.wbs_we_i, bus.wbs_sel_i,
                       bus.wbs_dat_i, bus.wbs_adr_i, bus.la_data_in, bus.la_oenb,
                       bus.io_in[IO_W-1:CELL_LSB+CELL_W], bus.io_in[CELL_LSB-1:0]
`ifndef UNIGATE_OUTREG_EN
                       , wb_clk_i, wb_rst_n
`endif
                      };

endmodule

// File: tb/tb_unigate_core.sv
// Self-checking bench for unigate_core against a rule-level reference model.
module tb_unigate_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  unigate_if bus();

  unigate_core dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  function automatic logic mu2(input logic g, input logic h, input logic i, input logic j);
    if (g) return h ^ j;
    return i ^ j;
  endfunction

  function automatic logic mu3(input logic g, input logic h, input logic i,
                               input logic j, input logic k, input logic l);
    if (g) return mu2(h, i, j, l);
    return k ^ l;
  endfunction

  // Expected r[5:0] for a given cell bus c[26:0]
  function automatic logic [5:0] model(input logic [26:0] c);
    logic [5:0]  r;
    logic [15:0] func;
    logic [3:0]  pin;
    logic [5:0]  f31;
    logic [9:0]  f41;
    logic [5:0]  f22;
    logic        a;
    logic        b;
    int          k;
    r = 6'b0;
    if (c[26] == 1'b1 && c[3:0] == 4'b0011) begin
      func = c[21:6];
      pin  = c[25:22];
      k    = int'(pin) % 4;
      case (c[5:4])
        2'd0: r[0] = func[4'(k)];
        2'd1: r[1] = func[4'(int'(pin) % 8)];
        2'd2: r[2] = func[pin];
        default: begin
          a = func[4'(k)];
          b = func[4'(k + 4)];
          r[3] = a;
          r[4] = b;
          r[5] = pin[2] ? b : a;
        end
      endcase
    end else begin
      f31 = c[9:4];
      f41 = c[19:10];
      f22 = c[25:20];
      r[0] = mu2(c[3], c[2], c[1], c[0]);
      r[1] = mu3(f31[5], f31[4], f31[3], f31[2], f31[1], f31[0]);
      r[2] = f41[9] ? mu3(f41[8], f41[7], f41[6], f41[5], f41[4], f41[0])
                    : mu2(f41[3], f41[2], f41[1], f41[0]);
      r[4] = mu2(f22[5], f22[4], f22[3], f22[0]);
      r[3] = mu2(f22[2], f22[1], f22[3], f22[0]);
      r[5] = c[26] ? r[4] : r[3];
    end
    return r;
  endfunction

  task automatic noise();
    bus.wbs_stb_i  = 1'($urandom);
    bus.wbs_cyc_i  = 1'($urandom);
    bus.wbs_we_i   = 1'($urandom);
    bus.wbs_sel_i  = 4'($urandom);
    bus.wbs_dat_i  = $urandom;
    bus.wbs_adr_i  = $urandom;
    bus.la_data_in = {$urandom, $urandom, $urandom, $urandom};
    bus.la_oenb    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Present c with random junk on the ignored pads, then wait until the result is due
  task automatic apply(input logic [26:0] c);
    @(negedge clk);
    noise();
    bus.io_in = {6'($urandom), c, 5'($urandom)};
`ifdef UNIGATE_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] c;
    c = 27'h0000_00C;
    apply(c);
    tests_run++;
`ifdef UNIGATE_OUTREG_EN
    if (bus.io_out[37:32] !== 6'b0) begin
      fails++;
      $display("FAIL reset_clear: io_out[37:32]=%b required %b", bus.io_out[37:32], 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== 6'b0) begin
      fails++;
      $display("FAIL reset_release_hold: io_out[37:32]=%b required %b", bus.io_out[37:32], 6'b0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== 6'b000001) begin
      fails++;
      $display("FAIL first_capture: io_out[37:32]=%b required %b", bus.io_out[37:32], 6'b000001);
    end
`else
    if (bus.io_out[37:32] !== 6'b000001) begin
      fails++;
      $display("FAIL reset_no_effect: io_out[37:32]=%b required %b", bus.io_out[37:32], 6'b000001);
    end
    rst_n = 1'b1;
`endif
    tests_run++;
    if (bus.io_oeb !== {6'b0, 32'hFFFF_FFFF}) begin
      fails++;
      $display("FAIL reset_oeb: io_oeb=%h required %h", bus.io_oeb, {6'b0, 32'hFFFF_FFFF});
    end
  endtask

  task automatic test_tieoffs();
    for (int n = 0; n < 6; n++) begin
      apply(27'($urandom));
      tests_run++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || bus.la_data_out !== 128'h0 ||
          bus.io_out[31:0] !== 32'h0 || bus.io_oeb !== {6'b0, 32'hFFFF_FFFF} ||
          bus.irq !== 3'b0) begin
        fails++;
        $display("FAIL tieoff: ack=%b dat=%h la=%h io_lo=%h oeb=%h irq=%b required all 0, oeb=%h",
                 bus.wbs_ack_o, bus.wbs_dat_o, bus.la_data_out, bus.io_out[31:0],
                 bus.io_oeb, bus.irq, {6'b0, 32'hFFFF_FFFF});
      end
    end
  endtask

  task automatic test_cells();
    logic [26:0] cv [5];
    logic [5:0]  ev [5];
    cv[0] = {1'b0, 6'b0,      10'b0,          6'b0, 4'b1100}; ev[0] = 6'b000001;
    cv[1] = {1'b0, 6'b0,      10'b0000001001, 6'b0, 4'b0000}; ev[1] = 6'b000100;
    cv[2] = {1'b0, 6'b0,      10'b0000001000, 6'b0, 4'b0000}; ev[2] = 6'b000000;
    cv[3] = {1'b1, 6'b110000, 10'b0,          6'b0, 4'b0000}; ev[3] = 6'b110000;
    cv[4] = {1'b0, 6'b110000, 10'b0,          6'b0, 4'b0000}; ev[4] = 6'b010000;
    for (int n = 0; n < 5; n++) begin
      apply(cv[n]);
      tests_run++;
      if (bus.io_out[37:32] !== ev[n]) begin
        fails++;
        $display("FAIL cell_vec%0d: r=%b required %b", n, bus.io_out[37:32], ev[n]);
      end
    end
  endtask

  task automatic test_ref_lut();
    logic [3:0] pin;
    logic [5:0] exp;
    for (int p = 0; p < 16; p++) begin
      pin = 4'(p);
      apply({1'b1, pin, 16'h8000, 2'b10, 4'b0011});
      exp = (p == 15) ? 6'b000100 : 6'b000000;
      tests_run++;
      if (bus.io_out[37:32] !== exp) begin
        fails++;
        $display("FAIL ref_and4 pin=%0d: r=%b required %b", p, bus.io_out[37:32], exp);
      end
      apply({1'b1, pin, 16'h6996, 2'b10, 4'b0011});
      exp = {3'b0, ^pin, 2'b0};
      tests_run++;
      if (bus.io_out[37:32] !== exp) begin
        fails++;
        $display("FAIL ref_parity pin=%0d: r=%b required %b", p, bus.io_out[37:32], exp);
      end
      apply({1'b1, pin, 16'h0008, 2'b00, 4'b0011});
      exp = (pin[1:0] == 2'b11) ? 6'b000001 : 6'b000000;
      tests_run++;
      if (bus.io_out[37:32] !== exp) begin
        fails++;
        $display("FAIL ref_sel0 pin=%0d: r=%b required %b", p, bus.io_out[37:32], exp);
      end
    end
  endtask

  task automatic test_random();
    logic [26:0] c;
    logic [5:0]  exp;
    for (int n = 0; n < 300; n++) begin
      c = 27'($urandom);
      if (n % 3 == 0) begin
        c[26]  = 1'b1;
        c[3:0] = 4'b0011;
      end
      exp = model(c);
      apply(c);
      tests_run++;
      if (bus.io_out[37:32] !== exp) begin
        fails++;
        $display("FAIL random c=%h: r=%b required %b", c, bus.io_out[37:32], exp);
      end
    end
  endtask

  task automatic test_timing();
    logic [26:0] c1;
    logic [26:0] c2;
    c1 = 27'($urandom);
    c2 = 27'($urandom);
    for (int n = 0; n < 200 && (model(c2) == model(c1) || model(c2) == 6'b0); n++)
      c2 = 27'($urandom);
    apply(c1);
    @(negedge clk);
    bus.io_in = {6'b0, c2, 5'b0};
    #1;
`ifdef UNIGATE_OUTREG_EN
    tests_run++;
    if (bus.io_out[37:32] !== model(c1)) begin
      fails++;
      $display("FAIL latency_hold: r=%b required %b", bus.io_out[37:32], model(c1));
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== model(c2)) begin
      fails++;
      $display("FAIL latency_one: r=%b required %b", bus.io_out[37:32], model(c2));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== 6'b0) begin
      fails++;
      $display("FAIL async_clear: r=%b required %b", bus.io_out[37:32], 6'b0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== 6'b0) begin
      fails++;
      $display("FAIL clear_held: r=%b required %b", bus.io_out[37:32], 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== model(c2)) begin
      fails++;
      $display("FAIL recapture: r=%b required %b", bus.io_out[37:32], model(c2));
    end
`else
    tests_run++;
    if (bus.io_out[37:32] !== model(c2)) begin
      fails++;
      $display("FAIL zero_latency: r=%b required %b", bus.io_out[37:32], model(c2));
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.io_out[37:32] !== model(c2)) begin
      fails++;
      $display("FAIL reset_ignored: r=%b required %b", bus.io_out[37:32], model(c2));
    end
    rst_n = 1'b1;
`endif
    tests_run++;
    if (bus.io_oeb !== {6'b0, 32'hFFFF_FFFF}) begin
      fails++;
      $display("FAIL timing_oeb: io_oeb=%h required %h", bus.io_oeb, {6'b0, 32'hFFFF_FFFF});
    end
  endtask

  initial begin
    bus.io_in = '0;
    noise();
    test_reset();
    test_tieoffs();
    test_cells();
    test_ref_lut();
    test_random();
    test_timing();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/unigate_core.md
# unigate_core

Caravel user-project core exposing a bank of configurable combinational logic cells on the GPIO pads. The cells are u21, u31, u41, a dual-output u22 and a select mux, all evaluated in parallel from io_in. A reference mode, decoded from a fixed pin pattern, replaces the cells with a truth-table lookup over up to 4 variables so the gate cells can be cross-checked on silicon. Wishbone, logic-analyzer and IRQ ports are tied off.

## Interface
- No parameters.
- wb_clk_i  in  1  clock; used only when output registers are compiled in
- wb_rst_n  in  1  asynchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  ignored
- wbs_sel_i  in  4  ignored
- wbs_dat_i, wbs_adr_i  in  32 each  ignored
- wbs_ack_o  out  1  constant 0
- wbs_dat_o  out  32  constant 0
- la_data_in, la_oenb  in  128 each  ignored
- la_data_out  out  128  constant 0
- io_in  in  38  cell inputs on [31:5]; other bits ignored
- io_out  out  38  results on [37:32]; [31:0] constant 0
- io_oeb  out  38  [37:32]=0 (driven), [31:0]=1 (input)
- irq  out  3  constant 0

## Operation
- Bus c[26:0] = io_in[31:5]. Fields, MSB first within each, letters g.. in order:
  - c[3:0]: u21 {g,h,i,j}
  - c[9:4]: u31 {g..l}
  - c[19:10]: u41 {g..p}
  - c[25:20]: u22 {g..l}
  - c[26]: mux select m
- Primitive U2(g,h,i,j) = g ? (h^j) : (i^j).
- Cell functions:
  - u21 = U2(g,h,i,j)
  - U3(g,h,i,j,k,l) = g ? U2(h,i,j,l) : (k^l); u31 = U3 of its field
  - u41 = g ? U3(h,i,j,k,l,p) : U2(m,n,o,p)
  - u22[1] = U2(g,h,i,l); u22[0] = U2(j,k,i,l)
  - mux = m ? u22[1] : u22[0]
- Normal result r[5:0] = {mux, u22[1], u22[0], u41, u31, u21}.
- Reference mode is active when c[26]=1 and c[3:0]=4'b0011. Normal-mode users must not present this pattern.
  - Decode: sel=c[5:4], func=c[21:6], pin=c[25:22].
  - sel 00: r[0] = func[pin[1:0]]
  - sel 01: r[1] = func[pin[2:0]]
  - sel 10: r[2] = func[pin[3:0]]
  - sel 11: r[3] = func[pin[1:0]], r[4] = func[4+pin[1:0]], r[5] = pin[2] ? r[4] : r[3]
  - All other r bits are 0 in reference mode.
- io_out[37:32] = r (direct or registered, see Configuration).

## Timing
- Default build: fully combinational, zero-cycle latency from io_in to io_out. Reset has no effect.
- Registered build: r is captured on the rising edge of wb_clk_i and appears one cycle later.
  - wb_rst_n low asynchronously clears io_out[37:32] to 0, including mid-operation.
  - The first capture occurs on the first rising edge after release.
- Tie-off outputs are constant in all builds and states.
- No handshake and no state machine.

## Configuration
- UNIGATE_OUTREG_EN:
  - Defined: io_out[37:32] comes from a 6-bit flop bank (wb_clk_i, async clear on wb_rst_n low).
  - Undefined: r drives the pads combinationally; no flops are inferred.

## Structure
- Shared package unigate_pkg:
  - field offsets and widths of c
  - reference-mode magic constants: bit 26 = 1 and 4'b0011
  - sel encodings SEL_U21=0, SEL_U31=1, SEL_U41=2, SEL_U22=3
- One sub-module, unigate_u2, implementing primitive U2. It is instantiated in all cells; U3 is built from it.
- Reference LUT and mode decode live in the top module.

## Test plan
- u21 field {1,1,0,0}, all other fields 0 -> io_out[37:32] = 6'b000001.
- u41 field 10'b0000001001 (m=1, p=1), rest 0 -> r[2] = 1. Flip p to 0 -> r[2] = 0.
- u22 field {g=1,h=1,i=0,j=0,k=0,l=0} with m=1 -> r = 6'b110000. Same field with m=0 -> r = 6'b010000.
- Reference mode, sel=10, func=16'h8000 -> r = 6'b000100 only for pin=4'b1111, 0 for the other 15 pins. func=16'h6996 -> r[2] = parity(pin).
- Reference mode, sel=00, func=16'h0008 -> r = 6'b000001 iff pin[1:0] = 2'b11.
- Registered build:
  - a result appears exactly one wb_clk_i cycle after its input change
  - asserting wb_rst_n low between edges clears io_out[37:32] immediately
  - io_oeb = {6'b0, 32'hFFFFFFFF} throughout
